// File: rtl/uart_time_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_time_tx
// Brief   : Snapshots four BCD timer digits and sends "MM:SS\r\n" as 8N1 serial.
// Rev     : 1.0  initial release
// ============================================================================
module uart_time_tx #(
  parameter int CLK_DIV = 2622,
  parameter int CNT_W   = 12
) (
  input  logic       MCLK,
  input  logic       RST_N,
  input  logic       SEND,
  input  logic [2:0] MIN_1,
  input  logic [3:0] MIN_0,
  input  logic [2:0] SEC_1,
  input  logic [3:0] SEC_0,
  input  logic       CTS,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_CTS = 3'd1,
    S_START    = 3'd2,
    S_DATA     = 3'd3,
    S_STOP     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]       LAST_BYTE = 3'd6;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [2:0]       byte_idx_q;
  logic [13:0]      snap_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       tx_byte;
  logic             bit_end;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : {4'h3, d};
  endfunction

  // snap_q layout: {MIN_1[2:0], MIN_0[3:0], SEC_1[2:0], SEC_0[3:0]}
  always_comb begin
    tx_byte = 8'h0A;
    case (byte_idx_q)
      3'd0:    tx_byte = digit_ascii({1'b0, snap_q[13:11]});
      3'd1:    tx_byte = digit_ascii(snap_q[10:7]);
      3'd2:    tx_byte = 8'h3A;
      3'd3:    tx_byte = digit_ascii({1'b0, snap_q[6:4]});
      3'd4:    tx_byte = digit_ascii(snap_q[3:0]);
      3'd5:    tx_byte = 8'h0D;
      default: tx_byte = 8'h0A;
    endcase
  end

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge MCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_idx_q <= '0;
      snap_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (SEND) begin
            snap_q     <= {MIN_1, MIN_0, SEC_1, SEC_0};
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_WAIT_CTS;
          end
        end
        S_WAIT_CTS: begin
          tx_q <= 1'b1;
          if (CTS) begin
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= tx_byte[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= tx_byte[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            cnt_q <= '0;
            if (byte_idx_q == LAST_BYTE) begin
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              byte_idx_q <= '0;
              state_q    <= S_IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 1'b1;
              state_q    <= S_WAIT_CTS;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TX   = tx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_time_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_time_tx
// Brief   : Scoreboard bench for uart_time_tx; a monitor decodes TX bytes.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_time_tx;

  localparam int DIV   = 4;
  localparam int FRAME = 7 * (10 * DIV + 1);

  logic       MCLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       SEND = 1'b0;
  logic [2:0] MIN_1 = '0;
  logic [3:0] MIN_0 = '0;
  logic [2:0] SEC_1 = '0;
  logic [3:0] SEC_0 = '0;
  logic       CTS = 1'b1;
  logic       TX, BUSY, DONE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;
  logic [7:0] sb_q[$];

  uart_time_tx #(.CLK_DIV(DIV), .CNT_W(3)) dut (
    .MCLK(MCLK), .RST_N(RST_N), .SEND(SEND),
    .MIN_1(MIN_1), .MIN_0(MIN_0), .SEC_1(SEC_1), .SEC_0(SEC_0),
    .CTS(CTS), .TX(TX), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 MCLK = ~MCLK;
  always @(posedge MCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_line(input string s);
    for (int i = 0; i < s.len(); i++) sb_q.push_back(8'(s[i]));
  endtask

  // Monitor: decode one frame; every bit must hold for exactly DIV samples.
  task automatic decode(output logic [7:0] b, output bit ok, output bit ab);
    ok = 1'b1; ab = 1'b0; b = '0;
    for (int j = 1; j < DIV; j++) begin
      @(negedge MCLK);
      if (!RST_N) begin ab = 1'b1; return; end
      if (TX !== 1'b0) ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < DIV; j++) begin
        @(negedge MCLK);
        if (!RST_N) begin ab = 1'b1; return; end
        if (j == 0) b[i] = TX;
        else if (TX !== b[i]) ok = 1'b0;
      end
    end
    for (int j = 0; j < DIV; j++) begin
      @(negedge MCLK);
      if (!RST_N) begin ab = 1'b1; return; end
      if (TX !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    bit ok, ab;
    forever begin
      @(negedge MCLK);
      if (RST_N && TX === 1'b0) begin
        decode(b, ok, ab);
        if (!ab) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %02h with empty scoreboard", b);
          end else begin
            e = sb_q.pop_front();
            if (!ok || b !== e) begin
              errors++;
              $display("FAIL tx_byte: got %02h (framing ok=%0d) expected %02h", b, ok, e);
            end
          end
        end
      end
    end
  end

  // Drive digits and SEND at a negedge; acceptance is seen at the next negedge.
  task automatic start_frame(input logic [2:0] m1, input logic [3:0] m0,
                             input logic [2:0] s1, input logic [3:0] s0,
                             input bit hold);
    MIN_1 = m1; MIN_0 = m0; SEC_1 = s1; SEC_0 = s0;
    SEND = 1'b1;
    @(negedge MCLK);
    chk("busy_on_accept", BUSY, 1'b1);
    chk("tx_high_on_accept", TX, 1'b1);
    acc = cyc;
    if (!hold) SEND = 1'b0;
    @(negedge MCLK);
    chk("tx_start_latency", TX, 1'b0);
  endtask

  task automatic wait_done(input int exp_len);
    int n = 0;
    while (!DONE && n < 5000) begin
      @(negedge MCLK);
      n++;
    end
    if (!DONE) begin
      checks++; errors++;
      $display("FAIL done_timeout: no DONE within %0d cycles", n);
    end else begin
      chk("frame_length", cyc - acc, exp_len);
      chk("busy_low_at_done", BUSY, 1'b0);
      chk("tx_high_at_done", TX, 1'b1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    RST_N = 1'b0;
    repeat (3) @(negedge MCLK);
    chk("reset_tx", TX, 1'b1);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_done", DONE, 1'b0);
    RST_N = 1'b1;
    repeat (2) @(negedge MCLK);

    // 1: basic line
    push_line("12:34\r\n");
    start_frame(3'd1, 4'd2, 3'd3, 4'd4, 1'b0);
    wait_done(FRAME);
    @(negedge MCLK);
    chk("done_one_cycle", DONE, 1'b0);
    chk("idle_busy", BUSY, 1'b0);
    repeat (3) @(negedge MCLK);

    // 2: inputs change mid-frame
    push_line("59:59\r\n");
    start_frame(3'd5, 4'd9, 3'd5, 4'd9, 1'b0);
    repeat (30) @(negedge MCLK);
    MIN_1 = 3'd0; MIN_0 = 4'd0; SEC_1 = 3'd0; SEC_0 = 4'd0;
    wait_done(FRAME);
    repeat (3) @(negedge MCLK);

    // 3: CTS held low before byte 3 for 50 cycles
    push_line("07:45\r\n");
    start_frame(3'd0, 4'd7, 3'd4, 4'd5, 1'b0);
    while (cyc < acc + 118) @(negedge MCLK);
    CTS = 1'b0;
    while (cyc < acc + 124) @(negedge MCLK);
    begin
      int bad = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge MCLK);
        if (TX !== 1'b1 || BUSY !== 1'b1) bad++;
      end
      chk("cts_hold_line", bad, 0);
    end
    c = cyc;
    CTS = 1'b1;
    @(negedge MCLK);
    chk("cts_resume_start", TX, 1'b0);
    wait_done(FRAME + (c - acc - 123));
    repeat (3) @(negedge MCLK);

    // 4: out-of-range digits
    push_line("1?:2?\r\n");
    start_frame(3'd1, 4'hC, 3'd2, 4'hF, 1'b0);
    wait_done(FRAME);
    repeat (3) @(negedge MCLK);

    // 5: SEND held high -> back-to-back frames, one idle cycle between
    push_line("36:12\r\n");
    push_line("36:12\r\n");
    start_frame(3'd3, 4'd6, 3'd1, 4'd2, 1'b1);
    wait_done(FRAME);
    @(negedge MCLK);
    chk("b2b_reaccept_busy", BUSY, 1'b1);
    chk("b2b_done_one_cycle", DONE, 1'b0);
    acc = cyc;
    SEND = 1'b0;
    wait_done(FRAME);
    repeat (3) @(negedge MCLK);

    // 6: reset during byte 2 data, then fresh frame
    push_line("42:07\r\n");
    start_frame(3'd4, 4'd2, 3'd0, 4'd7, 1'b0);
    while (cyc < acc + 95) @(negedge MCLK);
    chk("pre_reset_tx_low", TX, 1'b0);
    RST_N = 1'b0;
    #1;
    chk("async_reset_tx", TX, 1'b1);
    chk("async_reset_busy", BUSY, 1'b0);
    repeat (3) @(negedge MCLK);
    sb_q.delete();
    RST_N = 1'b1;
    repeat (3) @(negedge MCLK);
    push_line("10:53\r\n");
    start_frame(3'd1, 4'd0, 3'd5, 4'd3, 1'b0);
    wait_done(FRAME);
    repeat (10) @(negedge MCLK);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
